// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO slice.
//   clog2      : ceiling log2 helper for sizing address fields
//   DSIZE_DEF  : default data width
//   ASIZE_DEF  : default address width (depth = 1 << ASIZE)
package fifo_pkg;

   localparam int DSIZE_DEF = 8;
   localparam int ASIZE_DEF = 4;

   function automatic int clog2(input int value);
      int res;
      res = 0;
      while ((1 << res) < value) res++;
      return res;
   endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo: DEPTH x DSIZE dual-port RAM with a
// synchronous write port and an asynchronous read port.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational from raddr)
// Define FIFO_VENDOR_RAM to swap in a vendor macro with the same behaviour.
module sync_fifo_mem
   import fifo_pkg::*;
#(
   parameter int DSIZE = DSIZE_DEF,
   parameter int ASIZE = ASIZE_DEF
) (
   input  logic             clk,
   input  logic             we,
   input  logic [ASIZE-1:0] waddr,
   input  logic [DSIZE-1:0] wdata,
   input  logic [ASIZE-1:0] raddr,
   output logic [DSIZE-1:0] rdata
);

   localparam int DEPTH = 1 << ASIZE;

`ifdef FIFO_VENDOR_RAM
   vendor_dpram #(.DW(DSIZE), .AW(ASIZE)) u_ram (
      .clk   (clk),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .raddr (raddr),
      .rdata (rdata)
   );
`else
   // Not reset: contents are only meaningful once written.
   logic [DSIZE-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
`endif

endmodule

// File: rtl/sync_fifo.sv
// Single-clock parametrised FIFO.
//   clk, rst  : clock, asynchronous active-high reset
//   flush     : synchronous clear of contents and error flags (highest priority)
//   wr, wdata : write request and data
//   rd, rdata : read request and data (FWFT=1: head word shown combinationally;
//               FWFT=0: registered, loaded on each accepted read)
//   wfull, rempty, afull, aempty : registered status flags
//   count     : occupancy 0..DEPTH
//   overflow, underflow : sticky error flags for rejected write/read attempts
module sync_fifo
   import fifo_pkg::*;
#(
   parameter int DSIZE     = DSIZE_DEF,
   parameter int ASIZE     = ASIZE_DEF,
   parameter int AFULL_TH  = (1 << ASIZE) - 2,
   parameter int AEMPTY_TH = 2,
   parameter int FWFT      = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             wr,
   input  logic [DSIZE-1:0] wdata,
   input  logic             rd,
   output logic [DSIZE-1:0] rdata,
   output logic             wfull,
   output logic             rempty,
   output logic             afull,
   output logic             aempty,
   output logic [ASIZE:0]   count,
   output logic             overflow,
   output logic             underflow
);

   localparam int DEPTH = 1 << ASIZE;
   localparam logic [ASIZE:0] FULL_LVL   = (ASIZE+1)'(DEPTH);
   localparam logic [ASIZE:0] AFULL_LVL  = (ASIZE+1)'(AFULL_TH);
   localparam logic [ASIZE:0] AEMPTY_LVL = (ASIZE+1)'(AEMPTY_TH);

   logic [ASIZE-1:0] wptr, rptr;
   logic [ASIZE:0]   count_next;
   logic [DSIZE-1:0] mem_rdata;
   logic             wr_acc, rd_acc;

   // Acceptance uses the registered flags only, so wr/rd never reach a flag
   // combinationally. A full FIFO still accepts a read in the same cycle,
   // and an empty one still accepts a write.
   assign wr_acc = wr && !wfull  && !flush;
   assign rd_acc = rd && !rempty && !flush;

   always_comb begin
      count_next = count;
      if (flush) count_next = '0;
      else       count_next = count + (ASIZE+1)'(wr_acc) - (ASIZE+1)'(rd_acc);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr      <= '0;
         rptr      <= '0;
         count     <= '0;
         wfull     <= 1'b0;
         rempty    <= 1'b1;
         afull     <= 1'b0;
         aempty    <= 1'b1;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (flush) begin
            wptr      <= '0;
            rptr      <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
         end else begin
            if (wr_acc) wptr <= wptr + ASIZE'(1);
            if (rd_acc) rptr <= rptr + ASIZE'(1);
            if (wr && wfull)  overflow  <= 1'b1;
            if (rd && rempty) underflow <= 1'b1;
         end
         // Flags come from count_next so they track count exactly.
         count  <= count_next;
         wfull  <= (count_next == FULL_LVL);
         rempty <= (count_next == '0);
         afull  <= (count_next >= AFULL_LVL);
         aempty <= (count_next <= AEMPTY_LVL);
      end
   end

   sync_fifo_mem #(.DSIZE(DSIZE), .ASIZE(ASIZE)) u_mem (
      .clk   (clk),
      .we    (wr_acc),
      .waddr (wptr),
      .wdata (wdata),
      .raddr (rptr),
      .rdata (mem_rdata)
   );

   generate
      if (FWFT != 0) begin : g_fwft
         assign rdata = mem_rdata;
      end else begin : g_reg
         // Holds across flush and idle cycles; only an accepted read loads it.
         always_ff @(posedge clk or posedge rst) begin
            if (rst)         rdata <= '0;
            else if (rd_acc) rdata <= mem_rdata;
         end
      end
   endgenerate

endmodule

// File: tb/tb_sync_fifo.sv
module tb_sync_fifo;

   logic       clk = 1'b0;
   logic       rst;
   int         total = 0;
   int         bad   = 0;

   // instance 0: registered read
   logic       flush0, wr0, rd0;
   logic [7:0] wdata0, rdata0;
   logic       wfull0, rempty0, afull0, aempty0, overflow0, underflow0;
   logic [4:0] count0;

   // instance 1: first-word-fall-through
   logic       flush1, wr1, rd1;
   logic [7:0] wdata1, rdata1;
   logic       wfull1, rempty1, afull1, aempty1, overflow1, underflow1;
   logic [4:0] count1;

   always #5 clk = ~clk;

   sync_fifo #(.DSIZE(8), .ASIZE(4), .AFULL_TH(14), .AEMPTY_TH(2), .FWFT(0)) u0 (
      .clk(clk), .rst(rst), .flush(flush0), .wr(wr0), .wdata(wdata0), .rd(rd0),
      .rdata(rdata0), .wfull(wfull0), .rempty(rempty0), .afull(afull0),
      .aempty(aempty0), .count(count0), .overflow(overflow0), .underflow(underflow0)
   );

   sync_fifo #(.DSIZE(8), .ASIZE(4), .AFULL_TH(14), .AEMPTY_TH(2), .FWFT(1)) u1 (
      .clk(clk), .rst(rst), .flush(flush1), .wr(wr1), .wdata(wdata1), .rd(rd1),
      .rdata(rdata1), .wfull(wfull1), .rempty(rempty1), .afull(afull1),
      .aempty(aempty1), .count(count1), .overflow(overflow1), .underflow(underflow1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      flush0 = 0; wr0 = 0; rd0 = 0; wdata0 = 0;
      flush1 = 0; wr1 = 0; rd1 = 0; wdata1 = 0;
      tick(); tick();
      rst = 1'b0;
      tick();

      // reset state, registered-read instance
      chk("rst_count",  count0, 0);
      chk("rst_rempty", rempty0, 1);
      chk("rst_aempty", aempty0, 1);
      chk("rst_wfull",  wfull0, 0);
      chk("rst_afull",  afull0, 0);
      chk("rst_rdata",  rdata0, 0);
      chk("rst_ovf",    overflow0, 0);
      chk("rst_udf",    underflow0, 0);

      // fill with 0x01..0x10
      for (int i = 0; i < 16; i++) begin
         wr0 = 1; wdata0 = 8'(i + 1);
         tick();
         chk("fill_count",  count0, i + 1);
         chk("fill_afull",  afull0, (i + 1 >= 14) ? 1 : 0);
         chk("fill_wfull",  wfull0, (i + 1 == 16) ? 1 : 0);
         chk("fill_aempty", aempty0, (i + 1 <= 2) ? 1 : 0);
         chk("fill_rempty", rempty0, 0);
      end

      // write into full FIFO is dropped, overflow sticks
      wdata0 = 8'hAA;
      tick();
      wr0 = 0;
      chk("ovf_set",   overflow0, 1);
      chk("ovf_count", count0, 16);
      tick();
      chk("ovf_sticky", overflow0, 1);

      // drain: 0x01..0x10, one cycle after each rd
      for (int i = 0; i < 16; i++) begin
         rd0 = 1;
         tick();
         chk("drain_data",  rdata0, i + 1);
         chk("drain_count", count0, 15 - i);
      end
      rd0 = 0;
      chk("drain_rempty", rempty0, 1);
      chk("drain_wfull",  wfull0, 0);
      chk("drain_ovf",    overflow0, 1);
      chk("drain_udf",    underflow0, 0);

      // empty + wr + rd: write taken, read rejected
      wr0 = 1; rd0 = 1; wdata0 = 8'h5C;
      tick();
      wr0 = 0; rd0 = 0;
      chk("ewr_udf",   underflow0, 1);
      chk("ewr_count", count0, 1);
      chk("ewr_hold",  rdata0, 8'h10);
      rd0 = 1;
      tick();
      rd0 = 0;
      chk("ewr_data",  rdata0, 8'h5C);
      chk("ewr_empty", rempty0, 1);

      // preload 8 entries 0x20..0x27
      for (int i = 0; i < 8; i++) begin
         wr0 = 1; wdata0 = 8'(8'h20 + i);
         tick();
      end
      wr0 = 0;
      chk("pre_count", count0, 8);

      // 40 cycles of simultaneous wr+rd at count 8 (wraps pointers)
      for (int k = 0; k < 40; k++) begin
         wr0 = 1; rd0 = 1; wdata0 = 8'(8'h28 + k);
         tick();
         chk("steady_data",  rdata0, 8'h20 + k);
         chk("steady_count", count0, 8);
      end
      wr0 = 0; rd0 = 0;

      // top up to full (0x50..0x57), then overflow, then read half
      for (int i = 0; i < 8; i++) begin
         wr0 = 1; wdata0 = 8'(8'h50 + i);
         tick();
      end
      wdata0 = 8'hAA;
      tick();
      wr0 = 0;
      chk("half_full", wfull0, 1);
      chk("half_ovf",  overflow0, 1);
      for (int i = 0; i < 8; i++) begin
         rd0 = 1;
         tick();
         chk("half_data", rdata0, 8'h48 + i);
      end
      rd0 = 0;
      chk("half_count", count0, 8);

      // flush with wr=1: everything cleared, no write, rdata holds
      flush0 = 1; wr0 = 1; wdata0 = 8'h77;
      tick();
      flush0 = 0; wr0 = 0;
      chk("flush_count",  count0, 0);
      chk("flush_rempty", rempty0, 1);
      chk("flush_aempty", aempty0, 1);
      chk("flush_wfull",  wfull0, 0);
      chk("flush_ovf",    overflow0, 0);
      chk("flush_udf",    underflow0, 0);
      chk("flush_rdata",  rdata0, 8'h4F);
      tick();
      chk("flush_nowr", count0, 0);

      // FWFT instance: word visible without rd, rd pops
      chk("fw_rst_empty", rempty1, 1);
      wr1 = 1; wdata1 = 8'h3E;
      tick();
      wr1 = 0;
      chk("fw_rempty", rempty1, 0);
      chk("fw_data",   rdata1, 8'h3E);
      chk("fw_count",  count1, 1);
      rd1 = 1;
      tick();
      rd1 = 0;
      chk("fw_pop_count", count1, 0);
      chk("fw_pop_empty", rempty1, 1);
      wr1 = 1; wdata1 = 8'h11;
      tick();
      wdata1 = 8'h22;
      tick();
      wr1 = 0;
      chk("fw_head0", rdata1, 8'h11);
      rd1 = 1;
      tick();
      rd1 = 0;
      chk("fw_head1", rdata1, 8'h22);
      chk("fw_count1", count1, 1);

      // reset mid-burst is asynchronous
      for (int i = 0; i < 3; i++) begin
         wr0 = 1; wdata0 = 8'(8'h60 + i);
         tick();
      end
      rd0 = 1;
      tick();
      chk("burst_data", rdata0, 8'h60);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_count",  count0, 0);
      chk("arst_rempty", rempty0, 1);
      chk("arst_aempty", aempty0, 1);
      chk("arst_wfull",  wfull0, 0);
      chk("arst_afull",  afull0, 0);
      chk("arst_rdata",  rdata0, 0);
      chk("arst_ovf",    overflow0, 0);
      chk("arst_count1", count1, 0);
      chk("arst_rempty1", rempty1, 1);
      wr0 = 0; rd0 = 0;
      tick();
      rst = 1'b0;
      tick();
      chk("post_rst_count", count0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
